ras_circ: RTL and testbench

RAS_CIRC -- requirements
Module: ras_circ

---
 rtl/ras_circ.sv | 108 ++++++++++
 tb/tb_ras_circ.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/ras_circ.sv
// Circular return-address stack with checkpoint/restore of pointer and count.
// Pushes beyond capacity overwrite the oldest entry; the top entry is read combinationally.
module ras_circ #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [XLEN-1:0]            push_addr_i,
  input  logic                       pop_i,
  input  logic                       restore_i,
  input  logic [$clog2(DEPTH)-1:0]   restore_ptr_i,
  input  logic [$clog2(DEPTH):0]     restore_cnt_i,
  output logic [XLEN-1:0]            top_o,
  output logic                       top_valid_o,
  output logic [$clog2(DEPTH)-1:0]   ckpt_ptr_o,
  output logic [$clog2(DEPTH):0]     ckpt_cnt_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf;
  logic            r_unf;

  logic [PW-1:0]   w_ptr_nxt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            w_we;
  logic [PW-1:0]   w_waddr;
  logic            w_ovf_nxt;
  logic            w_unf_nxt;
  logic            w_full;
  logic            w_empty;

  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_empty = (r_cnt == '0);

  // Next-state decode in priority order: flush, restore, then push/pop.
  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    w_we      = 1'b0;
    w_waddr   = r_ptr;
    w_ovf_nxt = 1'b0;
    w_unf_nxt = 1'b0;
    if (flush_i) begin
      w_ptr_nxt = '0;
      w_cnt_nxt = '0;
    end else if (restore_i) begin
      w_ptr_nxt = restore_ptr_i;
      w_cnt_nxt = (restore_cnt_i > CW'(DEPTH)) ? CW'(DEPTH) : restore_cnt_i;
    end else if (push_i && pop_i && !w_empty) begin
      w_we    = 1'b1;
      w_waddr = r_ptr;
    end else if (push_i) begin
      w_ptr_nxt = r_ptr + PW'(1);
      w_we      = 1'b1;
      w_waddr   = r_ptr + PW'(1);
      if (w_full) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1);
      end
    end else if (pop_i) begin
      if (w_empty) begin
        w_unf_nxt = 1'b1;
      end else begin
        w_ptr_nxt = r_ptr - PW'(1);
        w_cnt_nxt = r_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      r_ovf <= w_ovf_nxt;
      r_unf <= w_unf_nxt;
      if (w_we) begin
        r_mem[w_waddr] <= push_addr_i;
      end
    end
  end

  assign top_o       = r_mem[r_ptr];
  assign top_valid_o = !w_empty;
  assign ckpt_ptr_o  = r_ptr;
  assign ckpt_cnt_o  = r_cnt;
  assign overflow_o  = r_ovf;
  assign underflow_o = r_unf;

endmodule

// File: tb/tb_ras_circ.sv
// Bench for ras_circ: directed vector table for the key scenarios, then
// random traffic checked against an array-based reference model.
module tb_ras_circ;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, push, pop, restore;
  logic [31:0] addr;
  logic [1:0]  rptr;
  logic [2:0]  rcnt;
  logic [31:0] top;
  logic        top_valid, ovf, unf;
  logic [1:0]  cptr;
  logic [2:0]  ccnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ras_circ #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .push_i(push),
    .push_addr_i(addr), .pop_i(pop), .restore_i(restore),
    .restore_ptr_i(rptr), .restore_cnt_i(rcnt),
    .top_o(top), .top_valid_o(top_valid), .ckpt_ptr_o(cptr),
    .ckpt_cnt_o(ccnt), .overflow_o(ovf), .underflow_o(unf)
  );

  typedef struct {
    logic        rst, flush, push, pop, restore;
    logic [1:0]  rptr;
    logic [2:0]  rcnt;
    logic [31:0] addr;
    logic [31:0] e_top;
    logic        e_valid;
    logic [1:0]  e_ptr;
    logic [2:0]  e_cnt;
    logic        e_ovf, e_unf;
  } vec_t;

  // Reference model: stack contents as a plain array indexed modulo DEPTH.
  logic [31:0] m_mem [DEPTH];
  int          m_ptr = 0;
  int          m_cnt = 0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  function automatic vec_t mk(input logic r, fl, pu, po, rs, input logic [1:0] rp,
                              input logic [2:0] rc, input logic [31:0] a,
                              input logic [31:0] et, input logic ev,
                              input logic [1:0] ep, input logic [2:0] ec,
                              input logic eo, eu);
    vec_t v;
    v.rst = r; v.flush = fl; v.push = pu; v.pop = po; v.restore = rs;
    v.rptr = rp; v.rcnt = rc; v.addr = a;
    v.e_top = et; v.e_valid = ev; v.e_ptr = ep; v.e_cnt = ec;
    v.e_ovf = eo; v.e_unf = eu;
    return v;
  endfunction

  task automatic model_step();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
      m_ptr = 0;
      m_cnt = 0;
    end else if (flush) begin
      m_ptr = 0;
      m_cnt = 0;
    end else if (restore) begin
      m_ptr = int'(rptr);
      m_cnt = (int'(rcnt) > int'(DEPTH)) ? int'(DEPTH) : int'(rcnt);
    end else if (push && pop && m_cnt > 0) begin
      m_mem[m_ptr] = addr;
    end else if (push) begin
      m_ptr = (m_ptr + 1) % int'(DEPTH);
      m_mem[m_ptr] = addr;
      if (m_cnt == int'(DEPTH)) m_ovf = 1'b1;
      else m_cnt = m_cnt + 1;
    end else if (pop) begin
      if (m_cnt > 0) begin
        m_ptr = (m_ptr + int'(DEPTH) - 1) % int'(DEPTH);
        m_cnt = m_cnt - 1;
      end else begin
        m_unf = 1'b1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One clock with the given inputs; the model advances in lockstep.
  task automatic cycle(input logic r, fl, pu, po, rs, input logic [1:0] rp,
                       input logic [2:0] rc, input logic [31:0] a);
    rst = r; flush = fl; push = pu; pop = po; restore = rs;
    rptr = rp; rcnt = rc; addr = a;
    @(posedge clk);
    model_step();
    #1;
  endtask

  vec_t vecs [$];

  initial begin
    rst = 0; flush = 0; push = 0; pop = 0; restore = 0;
    rptr = '0; rcnt = '0; addr = '0;
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;

    //             rst fl pu po rs rp rc addr        top        v  p  c  o  u
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h100, 32'h100,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h200, 32'h200,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h300, 32'h300,   1, 3, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h200,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h100,   1, 1, 1, 0, 0));
    // overflow: fifth push wraps onto the oldest slot
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h10,  32'h10,    1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h20,  32'h20,    1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h30,  32'h30,    1, 3, 3, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h40,  32'h40,    1, 0, 4, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h50,  32'h50,    1, 1, 4, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h40,    1, 0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h30,    1, 3, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h20,    1, 2, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h50,    0, 1, 0, 0, 0));
    // underflow pulse, then simultaneous push/pop on empty
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h50,    0, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h50,    0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 32'hAA,  32'hAA,    1, 2, 1, 0, 0));
    // checkpoint / restore, with restore count clamped to DEPTH
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h100, 32'h100,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h200, 32'h200,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h300, 32'h300,   1, 3, 3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h200,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 32'h0,   32'h100,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 2, 32'h0,   32'h200,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 7, 32'h0,   32'h200,   1, 2, 4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 2, 32'h0,   32'h200,   1, 2, 2, 0, 0));
    // replace-top, then flush beating a push
    vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 32'h999, 32'h999,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h123, 32'h0,     0, 0, 0, 0, 0));
    // reset beats a push at cnt=3
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h111, 32'h111,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h222, 32'h222,   1, 2, 2, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h333, 32'h333,   1, 3, 3, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 32'h444, 32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 32'h0,   32'h0,     0, 0, 0, 0, 0));
    // priority: flush over restore, restore over push, reset over everything
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 32'h555, 32'h555,   1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 3, 3, 32'h0,   32'h0,     0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 1, 1, 32'h666, 32'h555,   1, 1, 1, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 1, 3, 3, 32'h777, 32'h0,     0, 0, 0, 0, 0));

    foreach (vecs[k]) begin
      cycle(vecs[k].rst, vecs[k].flush, vecs[k].push, vecs[k].pop, vecs[k].restore,
            vecs[k].rptr, vecs[k].rcnt, vecs[k].addr);
      chk($sformatf("v%0d.top", k),   top,              vecs[k].e_top);
      chk($sformatf("v%0d.valid", k), 32'(top_valid),   32'(vecs[k].e_valid));
      chk($sformatf("v%0d.ptr", k),   32'(cptr),        32'(vecs[k].e_ptr));
      chk($sformatf("v%0d.cnt", k),   32'(ccnt),        32'(vecs[k].e_cnt));
      chk($sformatf("v%0d.ovf", k),   32'(ovf),         32'(vecs[k].e_ovf));
      chk($sformatf("v%0d.unf", k),   32'(unf),         32'(vecs[k].e_unf));
    end

    // Random traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom);
      chk($sformatf("r%0d.top", n),   top,            m_mem[m_ptr]);
      chk($sformatf("r%0d.valid", n), 32'(top_valid), 32'(m_cnt != 0));
      chk($sformatf("r%0d.ptr", n),   32'(cptr),      32'(m_ptr));
      chk($sformatf("r%0d.cnt", n),   32'(ccnt),      32'(m_cnt));
      chk($sformatf("r%0d.ovf", n),   32'(ovf),       32'(m_ovf));
      chk($sformatf("r%0d.unf", n),   32'(unf),       32'(m_unf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
